mul_issue_32: RTL
=================

# mul_issue_32

Issue/retire stage that sits directly upstream of `multiplier_32` and owns its control. It accepts a 32-bit multiply request over a valid/ready handshake, then launches the multiplier with its active-high `rst` start pulse. It waits for `dne`, applies the signed/unsigned high-word correction, and holds the selected 32-bit result on a valid/ready output until the consumer takes it.

## Interface
Parameters:
- TAG_W, 4, width of the request tag passed through to the result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; drops any in-flight op or held result.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHU (u×u high), 11 MULHSU (a signed × b unsigned, high).
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  request tag.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes result.
- res_data  out  32  result word.
- res_tag  out  TAG_W  tag of the result.
- mul_a  out  32  to multiplier `a`, held from accept until retire.
- mul_b  out  32  to multiplier `b`, held from accept until retire.
- mul_start  out  1  to multiplier `rst` (active-high start).
- mul_ena  out  1  to multiplier `ena`.
- mul_p  in  64  signed product from the multiplier.
- mul_dne  in  1  multiplier done.

## Operation
- States: IDLE, START, WAIT, FIX, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, a, b and tag, then go to START.
- START:
  - mul_start=1 for exactly this one cycle.
  - Always go to WAIT next.
- WAIT:
  - Sample mul_dne from the first cycle after START onward. Any stale dne seen during START is ignored.
  - Stay in WAIT while mul_dne=0.
  - On mul_dne=1, capture mul_p into a 64-bit register and go to FIX.
- FIX: compute the result word from the captured product P (sums taken mod 2^32) and go to DONE.
  - MUL: P[31:0].
  - MULH: P[63:32].
  - MULHU: P[63:32] + (a[31]?b:0) + (b[31]?a:0).
  - MULHSU: P[63:32] + (b[31]?a:0).
- DONE:
  - res_valid=1; res_data and res_tag are held stable.
  - On res_ready, go to IDLE.
- Only one op is in flight at a time. req_ready=0 in every state other than IDLE.
- flush=1: go to IDLE next cycle from any state. It takes priority over every other transition. res_valid falls, and a request presented in the same cycle is not accepted.
- mul_ena=1 whenever rst is high.

## Timing
- Reset (rst low, asynchronous):
  - State IDLE.
  - req_ready=1, res_valid=0, res_data=0, res_tag=0.
  - mul_a=0, mul_b=0, mul_start=0, mul_ena=0.
- Reset mid-operation aborts the op with no result. A multiplier mid-run is ignored and is restarted by the next START.
- Accept at edge k:
  - START is cycle k+1.
  - The first dne sample is cycle k+2.
  - If dne is first seen in cycle k+1+N: FIX is cycle k+2+N and res_valid rises at edge k+3+N.
- Result is held indefinitely under res_ready=0.
- DONE with res_ready=1 leads to IDLE next cycle. req_ready rises one cycle after the result handshake, so there is no same-cycle re-accept.
- All outputs are registered except req_ready and res_valid, which decode directly from the state register.

## Configuration
- MUL_ISSUE_ZERO_SKIP_EN defined:
  - In IDLE, a request with req_a==0 or req_b==0 goes directly to DONE with res_data=0.
  - Latency is 1 cycle; mul_start is never pulsed.
- Undefined: zero operands take the normal START/WAIT/FIX path, giving res_data=0 at full multiplier latency.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> res_data=0xFFFFFFEB with the tag echoed. Check that mul_start is one cycle wide.
- MULH a=b=0x7FFFFFFF -> 0x3FFFFFFF. Also check MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. Also check MULHU a=0x80000000, b=2 -> 0x00000001.
- Hold res_ready=0 for 20 cycles after res_valid -> res_data and res_valid stable and req_ready=0 throughout. Release -> IDLE next cycle.
- Drop rst in WAIT, and separately assert flush in DONE -> res_valid=0 and IDLE next cycle. A following MUL 3×5 returns 15.
- Zero operand: MUL a=0, b=0x12345678 -> res_data=0. With MUL_ISSUE_ZERO_SKIP_EN: res_valid one cycle after accept and no mul_start. Without it: normal latency.

Source files
------------

// File: rtl/mul_issue_32.sv
// ---------------------------------------------------------------------------
// mul_issue_32
//
// Issue/retire control stage in front of multiplier_32. Accepts one 32x32
// multiply request at a time over a valid/ready handshake, launches the
// multiplier with a one-cycle start pulse, waits for its done flag, converts
// the signed 64-bit product into the requested result word (low word, or the
// high word for signed x signed, unsigned x unsigned, or signed x unsigned)
// and holds that word on a valid/ready output until the consumer takes it.
//
// Optional build macro:
//   MUL_ISSUE_ZERO_SKIP_EN - when defined, a request with a zero operand
//                            bypasses the multiplier and completes with a
//                            zero result one cycle after acceptance.
//
// Parameters:
//   TAG_W      width of the request tag carried through to the result
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous abort of any in-flight op or held result
//   req_valid  request present
//   req_ready  block can accept a request (decoded from state)
//   req_op     00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
//   req_a      operand A
//   req_b      operand B
//   req_tag    request tag
//   res_valid  result present (decoded from state)
//   res_ready  consumer takes the result
//   res_data   result word
//   res_tag    tag belonging to res_data
//   mul_a      multiplier operand A, held from accept until retire
//   mul_b      multiplier operand B, held from accept until retire
//   mul_start  multiplier start pulse (drives the multiplier's rst)
//   mul_ena    multiplier enable
//   mul_p      signed 64-bit product from the multiplier
//   mul_dne    multiplier done
// ---------------------------------------------------------------------------
module mul_issue_32 #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_start,
    output logic             mul_ena,
    input  logic [63:0]      mul_p,
    input  logic             mul_dne
);

`ifdef MUL_ISSUE_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        FIX,
        DONE
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic [TAG_W-1:0]      tag_q;
    logic signed [63:0]    prod_p0;
    logic                  accept;
    logic                  zero_op;

    // The multiplier always produces the signed x signed product. A negative
    // operand in two's complement stands for (value - 2^32), so the signed
    // product is short of the unsigned interpretation by 2^32 times the other
    // operand for each operand with its top bit set. Adding that operand back
    // into the high word restores the unsigned (or mixed) high word.
    function automatic logic [31:0] fix_result(
        input logic [1:0]         op,
        input logic signed [63:0] p,
        input logic [31:0]        a,
        input logic [31:0]        b
    );
        logic [31:0] hi;
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        logic [31:0] word;
        hi     = p[63:32];
        corr_a = a[31] ? b : 32'd0;
        corr_b = b[31] ? a : 32'd0;
        case (op)
            OP_MUL:   word = p[31:0];
            OP_MULH:  word = hi;
            OP_MULHU: word = hi + corr_a + corr_b;
            default:  word = hi + corr_b;
        endcase
        return word;
    endfunction

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign accept    = (state == IDLE) && req_valid && !flush;
    assign zero_op   = (req_a == 32'd0) || (req_b == 32'd0);

    // Control and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            res_data  <= '0;
            res_tag   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            mul_ena   <= 1'b0;
        end else begin
            mul_ena   <= 1'b1;
            mul_start <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            mul_a <= req_a;
                            mul_b <= req_b;
                            if (ZERO_SKIP && zero_op) begin
                                res_data <= '0;
                                res_tag  <= req_tag;
                                state    <= DONE;
                            end else begin
                                mul_start <= 1'b1;
                                state     <= START;
                            end
                        end
                    end
                    // A done flag still high from the previous op is visible
                    // here; START never looks at it.
                    START: state <= WAIT;
                    WAIT: begin
                        if (mul_dne) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        res_data <= fix_result(op_q, prod_p0, mul_a, mul_b);
                        res_tag  <= tag_q;
                        state    <= DONE;
                    end
                    DONE: begin
                        if (res_ready) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage p0: request fields and captured product
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= req_op;
            tag_q <= req_tag;
        end
        if ((state == WAIT) && mul_dne && !flush) begin
            prod_p0 <= $signed(mul_p);
        end
    end

endmodule
